// File: rtl/mdu_pkg.sv
// Shared op codes, FSM states and op classification for the multiply/divide unit.
// MDU_MADD_EN enables the multiply-accumulate op family.
package mdu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Accumulate ops run on the multiplier timing, so they count as mult-class.
    function automatic logic is_mult_class(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div_class(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational result path: latched operands and current {HI,LO} to next {HI,LO}.
// Divide-by-zero and undefined ops return {HI,LO} unchanged.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_next_o,
    output logic [DATA_W-1:0] lo_next_o
);

    // Most-negative / -1 overflows the quotient; it wraps to the dividend with zero remainder.
    function automatic logic [2*DATA_W-1:0] div_signed(input logic [DATA_W-1:0] n,
                                                       input logic [DATA_W-1:0] d);
        logic signed [DATA_W-1:0] q;
        logic signed [DATA_W-1:0] r;
        if (n == {1'b1, {(DATA_W-1){1'b0}}} && d == {DATA_W{1'b1}}) begin
            q = $signed(n);
            r = '0;
        end else begin
            q = $signed(n) / $signed(d);
            r = $signed(n) % $signed(d);
        end
        return {r, q};
    endfunction

    logic signed [2*DATA_W-1:0] a_s, b_s, prod_s;
    logic        [2*DATA_W-1:0] a_u, b_u, prod_u;
    logic        [2*DATA_W-1:0] acc, res;
    logic                       div_zero;

    always_comb begin
        a_s      = {{DATA_W{a_i[DATA_W-1]}}, a_i};
        b_s      = {{DATA_W{b_i[DATA_W-1]}}, b_i};
        a_u      = {{DATA_W{1'b0}}, a_i};
        b_u      = {{DATA_W{1'b0}}, b_i};
        prod_s   = a_s * b_s;
        prod_u   = a_u * b_u;
        acc      = {hi_i, lo_i};
        div_zero = (b_i == '0);
        res      = acc;
        case (op_i)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   if (!div_zero) res = div_signed(a_i, b_i);
            OP_DIVU:  if (!div_zero) res = {a_i % b_i, a_i / b_i};
`ifdef MDU_MADD_EN
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
`endif
            default:  res = acc;
        endcase
        hi_next_o = res[2*DATA_W-1:DATA_W];
        lo_next_o = res[DATA_W-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; fixed-latency FSM with registered busy.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0] res_hi, res_lo;
    logic              accept_mul, accept_div, done;

    mdu_arith u_arith (
        .op_i      (op_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .hi_next_o (res_hi),
        .lo_next_o (res_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        accept_mul = (state_q == ST_IDLE) && start && is_mult_class(op);
        accept_div = (state_q == ST_IDLE) && start && is_div_class(op);
        done       = (state_q == ST_RUN) && (cnt_q == CNT_W'(1));
        state_d    = state_q;
        case (state_q)
            ST_IDLE: if (accept_mul || accept_div) state_d = ST_RUN;
            ST_RUN:  if (done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Starts arriving while RUN fall through untouched: only IDLE latches operands or MT writes.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (accept_mul || accept_div) begin
            cnt_d = accept_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
            op_d  = op;
            a_d   = rs_val;
            b_d   = rt_val;
        end else if (state_q == ST_IDLE && start && op == OP_MTHI) begin
            hi_d = rs_val;
        end else if (state_q == ST_IDLE && start && op == OP_MTLO) begin
            lo_d = rs_val;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (done) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    always_comb begin
        busy = (state_q == ST_RUN);
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected {HI,LO,busy length},
// a monitor pops and compares each time busy falls.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb_q[$];

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int len);
        exp_t e;
        e.name = name;
        e.hi   = h;
        e.lo   = l;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: busy still high after 40 cycles", name);
        end
    endtask

    // Monitor: count busy cycles and check the result on each falling edge of busy.
    initial begin
        int   run_len;
        logic prev_busy;
        exp_t e;
        run_len   = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                run_len++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: got hi=%h lo=%h, no entry queued", hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_busy_len"}, 32'(run_len), 32'(e.len));
                end
                run_len = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_busy;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 4'd0;
        rs_val = '0;
        rt_val = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);

        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(4'd0, 32'hFFFF_FFFE, 32'd3);
        wait_idle("mult");

        push("multu", 32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue(4'd1, 32'hFFFF_FFFE, 32'd3);
        wait_idle("multu");

        push("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(4'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div");

        push("divu", 32'd1, 32'd3, 10);
        issue(4'd3, 32'd7, 32'd2);
        wait_idle("divu");

        push("div_ovf", 32'h0, 32'h8000_0000, 10);
        issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf");

        // MTHI then MTLO on back-to-back edges
        @(posedge clk);
        #1;
        start  = 1'b1;
        op     = 4'd4;
        rs_val = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        op     = 4'd5;
        rs_val = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);

        push("div_by_zero", 32'h1234_5678, 32'h9ABC_DEF0, 10);
        issue(4'd2, 32'd55, 32'd0);
        wait_idle("div_by_zero");

        // DIV 100 / -7 with a MULT start sampled at RUN cycle 3
        push("div_ignore_start", 32'd2, 32'hFFFF_FFF2, 10);
        issue(4'd2, 32'd100, 32'hFFFF_FFF9);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        start  = 1'b1;
        op     = 4'd0;
        rs_val = 32'd5;
        rt_val = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("div_ignore_start");

        // Reset sampled at the 4th edge of a DIVU aborts it
        push("div_abort", 32'h0, 32'h0, 4);
        issue(4'd3, 32'd7, 32'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_write_hi", hi, 32'h0);
        chk("abort_no_write_lo", lo, 32'h0);

`ifdef MDU_MADD_EN
        issue(4'd4, 32'h0, 32'h0);
        issue(4'd5, 32'hFFFF_FFFF, 32'h0);
        push("maddu", 32'd1, 32'd0, 5);
        issue(4'd7, 32'd1, 32'd1);
        wait_idle("maddu");

        issue(4'd4, 32'h0, 32'h0);
        issue(4'd5, 32'h0, 32'h0);
        push("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        issue(4'd8, 32'd1, 32'd1);
        wait_idle("msub");
`else
        issue(4'd4, 32'hA5A5_A5A5, 32'h0);
        issue(4'd5, 32'h5A5A_5A5A, 32'h0);
        seen_busy = 1'b0;
        issue(4'd6, 32'd1, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        chk("op6_no_busy", {31'b0, seen_busy}, 32'd0);
        chk("op6_hi", hi, 32'hA5A5_A5A5);
        chk("op6_lo", lo, 32'h5A5A_5A5A);
        issue(4'd15, 32'd1, 32'd1);
        @(negedge clk);
        chk("op15_no_busy", {31'b0, busy}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit in the EX stage of the five-stage pipelined MIPS CPU. It accepts MULT/MULTU/DIV/DIVU plus MTHI/MTLO from EX, runs each arithmetic op for a fixed latency, and owns the architectural HI/LO registers. MFHI/MFLO read its outputs. Its `busy` output drives the ID-stage hazard unit, which stalls any mult/div-class instruction while the unit is occupied.

## Interface
- `MULT_LAT`, 5, cycles from accepted MULT/MULTU (and MADD-class) to HI/LO update
- `DIV_LAT`, 10, cycles from accepted DIV/DIVU to HI/LO update
- `clk`  input  1  pipeline clock; all state changes on rising edge
- `reset`  input  1  synchronous, active-high; clears all state
- `start`  input  1  one-cycle pulse: EX holds a valid mult/div-class instruction
- `op`  input  4  operation code (encoding in package), sampled when `start`=1
- `rs_val`  input  32  forwarded GPR[rs]; dividend/multiplicand/MT source
- `rt_val`  input  32  forwarded GPR[rt]; divisor/multiplier
- `busy`  output  1  operation in flight
- `hi`  output  32  architectural HI
- `lo`  output  32  architectural LO

## Operation
- States: IDLE, RUN. Down-counter `cnt`, width clog2(max(MULT_LAT,DIV_LAT))+1.
- IDLE, `start`=1, arithmetic op: latch operands and op, `cnt`<=MULT_LAT or DIV_LAT, go RUN.
- IDLE, `start`=1, MTHI/MTLO: write `rs_val` to HI/LO at that edge; stay IDLE; `busy` never asserts.
- RUN: `cnt` decrements each cycle; at the edge where `cnt`==1, write result to HI/LO and return to IDLE.
- `start` while RUN: ignored (hazard unit guarantees it does not occur). Operands and result stay unaffected.
- MULT: signed 32x32->64; HI=[63:32], LO=[31:0]. MULTU: same, unsigned.
- DIV: signed; LO=quotient truncated toward zero, HI=remainder with sign of dividend. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU: unsigned.
- Divide by zero (`rt_val`=0): full DIV_LAT busy period; HI/LO left unchanged.
- Undefined `op` with `start`: ignored, stays IDLE.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0.
- `start` sampled at edge k. `busy`=1 from after edge k through edge k+LAT. HI/LO show the new value after edge k+LAT, the same edge at which `busy` falls.
- `busy` is registered. The hazard unit ORs `start` with `busy` for the start cycle.
- MTHI/MTLO: new value visible after the edge at which `start` is sampled. Latency 1, no busy.
- `hi`/`lo` are direct register outputs. MFHI/MFLO in EX read the previous value until the update edge.
- Reset asserted mid-operation aborts the operation. The in-flight result is never written.

## Configuration
- `MDU_MADD_EN` defined: ops MADD, MADDU, MSUB, MSUBU accepted.
  - Each computes the 64-bit product (signed/unsigned) and adds it to, or subtracts it from, {HI,LO}, modulo 2^64.
  - {HI,LO} is read at the completion edge.
  - Latency is MULT_LAT.
- `MDU_MADD_EN` undefined: those codes are treated as undefined ops and ignored.

## Structure
- Package `mdu_pkg`:
  - op codes: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9
  - state enum (IDLE, RUN)
  - helper function classifying an op as mult-class or div-class
- Sub-module `mdu_arith`: combinational block from latched operands, op, and current {HI,LO} to the 64-bit result {hi_next, lo_next}, including the divide-by-zero hold. The top holds the FSM, counter and HI/LO registers.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=3 -> `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x2, LO=0xFFFFFFFA.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> `busy` stays 0; HI/LO updated one edge after each `start`. Then DIV by 0 -> 10 busy cycles, HI/LO unchanged.
- DIV started, `start`+MULT pulsed at cycle 3 of RUN -> ignored; the DIV result lands at cycle 10. Reset asserted at cycle 4 of a second DIV -> `busy`=0, HI=LO=0 after that edge, and no later write.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, MADDU 1×1 -> HI=1, LO=0 after 5 cycles. MSUB 1×1 from {0,0} -> HI=LO=0xFFFFFFFF. Without the macro, op 6 -> no busy, HI/LO unchanged.
